hilo_divider: RTL and testbench
===============================

// Module: hilo_divider
// PURPOSE
//  Iterative 32-bit divider for DIV/DIVU. Sits directly downstream of the register
//  file: it takes the Rs (dividend) and Rt (divisor) read ports as operands.
//  It produces the quotient (LO) and remainder (HI) for the HI/LO write-back path.
//  It is a multi-cycle unit, so the control unit stalls the pipeline while DIV_busy is high.
// PARAMETERS
//  WIDTH   32   operand/result width; the iteration count equals WIDTH
// PORTS
//  DIV_clk       in   1      clock; all state changes on posedge
//  DIV_rst_n     in   1      asynchronous, active-low reset
//  DIV_start     in   1      start request; sampled only when idle
//  DIV_signed    in   1      1 = DIV (two's complement), 0 = DIVU
//  DIV_dividend  in   WIDTH  dividend, from the regfile Rs port
//  DIV_divisor   in   WIDTH  divisor, from the regfile Rt port
//  DIV_q         out  WIDTH  quotient, routed to LO
//  DIV_r         out  WIDTH  remainder, routed to HI
//  DIV_busy      out  1      high whenever the state is not IDLE
//  DIV_done      out  1      one-cycle pulse; DIV_q/DIV_r are valid from this cycle onward
//  DIV_div0      out  1      divisor was zero for the last op; held until the next accepted start
// BEHAVIOUR
//  Reset (async, DIV_rst_n=0)
//   - State goes to IDLE immediately.
//   - DIV_q, DIV_r, DIV_busy, DIV_done and DIV_div0 all go to 0; the count and internal regs clear.
//   - Reset during CALC aborts the operation; no done pulse is produced.
//  States: IDLE, CALC, FIX.
//  IDLE
//   - On posedge with DIV_start=1: latch operands, clear DIV_div0.
//   - Signed mode: latch |dividend| and |divisor|; record neg_q = sign(dvd)^sign(dvs) and neg_r = sign(dvd).
//   - Unsigned mode: neg_q = neg_r = 0.
//   - If divisor != 0: set the partial remainder to 0 and count to 0, then go to CALC.
//   - If divisor == 0: go to FIX with the special result (see the divide-by-zero rule below).
//  CALC (restoring algorithm, one quotient bit per cycle, MSB first)
//   - Shift {rem, dvd} left by 1.
//   - If rem >= divisor magnitude: subtract it and set the new quotient bit to 1.
//   - The trial subtract is WIDTH+1 bits wide, so there is no overflow with unsigned magnitudes.
//   - count increments each cycle; after the WIDTH-th step go to FIX.
//  FIX
//   - DIV_q = neg_q ? -mag_q : mag_q.
//   - DIV_r = neg_r ? -mag_r : mag_r.
//   - Assert DIV_done for exactly 1 cycle, then go to IDLE.
//  Latency
//   - Start accepted at edge k; results and DIV_done appear after edge k+WIDTH+1 (k+33).
//   - DIV_busy is high after edge k through edge k+33 and is low in the DIV_done cycle.
//   - A new DIV_start in the DIV_done cycle is accepted (back-to-back ops allowed).
//  Start while busy: ignored. Operand changes while busy: ignored (operands already latched).
//  Outputs hold their last values until the next FIX; they are not cleared on start.
//  Divide by zero
//   - Path: IDLE -> FIX, so DIV_done comes after edge k+1.
//   - DIV_q = all ones, DIV_r = dividend exactly as presented, DIV_div0 = 1.
//   - Sign fix-up is not applied to this result.
//  Signed overflow: 0x80000000 / -1 gives q = 0x80000000, r = 0 (natural wrap, no flag).
//  Sign rules: quotient truncates toward zero; nonzero remainder takes the dividend's sign (MIPS semantics).
// TESTING
//  1. DIVU 100/7 with start at edge k -> q=14, r=2; done only after edge k+33; busy high for 33 cycles.
//  2. DIV -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); DIV 7/-2 -> q=-3, r=1.
//  3. DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0; DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//  4. DIV 5/0 -> done after edge k+1, q=0xFFFFFFFF, r=5, div0=1; next valid op clears div0.
//  5. Start pulses and operand changes during CALC -> ignored, result unchanged.
//     Start held in the done cycle -> second op accepted, done 34 cycles later.
//  6. DIV_rst_n low at CALC cycle 10 -> all outputs 0, IDLE, no done.
//     After release, DIVU 9/3 -> q=3, r=0.

Source files
------------

// File: rtl/hilo_divider.sv
// Iterative restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// One quotient bit per cycle on magnitudes, with a final sign fix-up state.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             DIV_clk,
  input  logic             DIV_rst_n,
  input  logic             DIV_start,
  input  logic             DIV_signed,
  input  logic [WIDTH-1:0] DIV_dividend,
  input  logic [WIDTH-1:0] DIV_divisor,
  output logic [WIDTH-1:0] DIV_q,
  output logic [WIDTH-1:0] DIV_r,
  output logic             DIV_busy,
  output logic             DIV_done,
  output logic             DIV_div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             zero_reg;
  logic             done_reg;
  logic             div0_reg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             take;

  assign dvd_neg = DIV_signed & DIV_dividend[WIDTH-1];
  assign dvs_neg = DIV_signed & DIV_divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -DIV_dividend : DIV_dividend;
  assign dvs_mag = dvs_neg ? -DIV_divisor : DIV_divisor;

  // Quotient register doubles as the dividend shift register; its MSB feeds the remainder.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};
  assign take    = ~trial[WIDTH];

  always_ff @(posedge DIV_clk or negedge DIV_rst_n) begin
    if (!DIV_rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      zero_reg  <= 1'b0;
      done_reg  <= 1'b0;
      div0_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (DIV_start) begin
            div0_reg  <= 1'b0;
            count_reg <= '0;
            if (DIV_divisor == '0) begin
              // Preload the special result so FIX passes it through unchanged.
              quo_reg   <= '1;
              rem_reg   <= DIV_dividend;
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
              zero_reg  <= 1'b1;
              state_reg <= FIX;
            end else begin
              quo_reg   <= dvd_mag;
              dvs_reg   <= dvs_mag;
              rem_reg   <= '0;
              neg_q_reg <= dvd_neg ^ dvs_neg;
              neg_r_reg <= dvd_neg;
              zero_reg  <= 1'b0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg   <= take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_reg   <= {quo_reg[WIDTH-2:0], take};
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST_STEP) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          q_reg     <= neg_q_reg ? -quo_reg : quo_reg;
          r_reg     <= neg_r_reg ? -rem_reg : rem_reg;
          div0_reg  <= zero_reg;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign DIV_q    = q_reg;
  assign DIV_r    = r_reg;
  assign DIV_busy = (state_reg != IDLE);
  assign DIV_done = done_reg;
  assign DIV_div0 = div0_reg;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed-vector bench for hilo_divider: results, latency, busy window, div0 and reset abort.
module tb_hilo_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div0;

  int tests_run    = 0;
  int tests_failed = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .DIV_clk      (clk),
    .DIV_rst_n    (rst_n),
    .DIV_start    (start),
    .DIV_signed   (sgn),
    .DIV_dividend (dividend),
    .DIV_divisor  (divisor),
    .DIV_q        (q),
    .DIV_r        (r),
    .DIV_busy     (busy),
    .DIV_done     (done),
    .DIV_div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // One operation: start accepted at edge k, then count edges until done (bounded).
  task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ediv0,
                       input int elat, input bit disturb, input logic [31:0] prev_q);
    int lat;
    int busy_cnt;
    @(negedge clk);
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
      if (disturb && lat == 5) begin
        check_val({tag, " q_held"}, q, prev_q);
        start = 1'b1; dividend = $urandom; divisor = 32'd3; sgn = ~s;
      end
      if (disturb && lat == 8) start = 1'b0;
    end
    check_val({tag, " latency"}, 32'(lat), 32'(elat));
    check_val({tag, " busy_cycles"}, 32'(busy_cnt), 32'(elat));
    check_val({tag, " q"}, q, eq);
    check_val({tag, " r"}, r, er);
    check_val({tag, " div0"}, {31'd0, div0}, {31'd0, ediv0});
    @(posedge clk); #1;
    check_val({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcnt;
    rst_n = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst q", q, 32'd0);
    check_val("rst r", r, 32'd0);
    check_val("rst busy", {31'd0, busy}, 32'd0);
    check_val("rst done", {31'd0, done}, 32'd0);
    check_val("rst div0", {31'd0, div0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0, 32'd0);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 32'd0);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0, 32'd0);
    do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0, 32'd0);
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0, 32'd0);
    do_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0, 32'd0);
    do_op("divu_3_5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 33, 1'b0, 32'd0);

    do_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b0, 32'd0);
    check_val("div0_held", {31'd0, div0}, 32'd1);
    do_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b0, 32'd0);
    do_op("divu_after_div0", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33, 1'b0, 32'd0);

    do_op("disturb_1000_33", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33, 1'b1, 32'd3);

    // Start held high across the whole first op so it is re-sampled in the done cycle.
    @(negedge clk);
    sgn = 1'b0; dividend = 32'h1234_5678; divisor = 32'h0000_0100; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("b2b first latency", 32'(lat), 32'd33);
    check_val("b2b first q", q, 32'h0012_3456);
    check_val("b2b first r", r, 32'h0000_0078);
    sgn = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 100);
    check_val("b2b second latency", 32'(lat), 32'd34);
    check_val("b2b second q", q, 32'hFFFF_FFF2);
    check_val("b2b second r", r, 32'hFFFF_FFFE);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    sgn = 1'b0; dividend = 32'd50000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort q", q, 32'd0);
    check_val("abort r", r, 32'd0);
    check_val("abort busy", {31'd0, busy}, 32'd0);
    check_val("abort done", {31'd0, done}, 32'd0);
    check_val("abort div0", {31'd0, div0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_val("abort no_done", 32'(dcnt), 32'd0);
    check_val("abort idle", {31'd0, busy}, 32'd0);
    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
